// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Brief    : Gate-window edge counter and edge-to-edge period meter for a
//            slow asynchronous input, sampled in the clkin domain.
// Revision : 1.0 - initial release
// ============================================================================
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             no_signal
);

  // The gate counter is sized from the window length, not CNT_W, so a narrow
  // count width can still run a long window.
  localparam int                c_GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [c_GATE_W-1:0] c_GATE_LAST = c_GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t                r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  r_prev;
  logic [c_GATE_W-1:0]   r_gate_cnt;
  logic [CNT_W-1:0]      r_edge_cnt;
  logic [CNT_W-1:0]      r_per_cnt;
  logic                  r_armed;

  logic                  w_edge;
  logic [CNT_W-1:0]      w_edge_sum;
  logic [CNT_W-1:0]      w_per_inc;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_edge_sum = (r_edge_cnt == c_CNT_MAX) ? c_CNT_MAX : r_edge_cnt + CNT_W'(w_edge);
  assign w_per_inc  = (r_per_cnt == c_CNT_MAX) ? c_CNT_MAX : r_per_cnt + CNT_W'(1);

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_per_cnt    <= '0;
      r_armed      <= 1'b0;
      freq_count   <= '0;
      freq_valid   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      no_signal    <= 1'b0;
    end else begin
      freq_valid   <= 1'b0;
      period_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_per_cnt  <= '0;
          r_armed    <= 1'b0;
          if (en) r_state <= GATE;
        end
        GATE: begin
          if (!en) begin
            // Abort: the partial window is dropped and the outputs keep their values.
            r_state    <= IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_armed    <= 1'b0;
          end else begin
            if (r_gate_cnt == c_GATE_LAST) begin
              freq_count <= w_edge_sum;
              freq_valid <= 1'b1;
              no_signal  <= (w_edge_sum == '0);
              r_gate_cnt <= '0;
              r_edge_cnt <= '0;
            end else begin
              r_gate_cnt <= r_gate_cnt + c_GATE_W'(1);
              r_edge_cnt <= w_edge_sum;
            end
            if (w_edge) begin
              r_per_cnt <= CNT_W'(1);
              r_armed   <= 1'b1;
              if (r_armed) begin
                period       <= r_per_cnt;
                period_valid <= 1'b1;
              end
            end else begin
              r_per_cnt <= w_per_inc;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Frequency and period measurement block, the counterpart of the clock divider: it measures a slow external or divided signal rather than generating one. It synchronizes an asynchronous input `sig_in` into the `clkin` domain and detects its rising edges. It counts those edges over a fixed gate window to report frequency, and counts `clkin` cycles between consecutive edges to report period. It is used for self-check of divided clocks and for board-level frequency readout.

Parameters:
- GATE_CYCLES, 50000000, gate window length in `clkin` cycles (1 s at 50 MHz); must be >= 2.
- CNT_W, 32, width of all count and period outputs and internal counters.
- SYNC_STAGES, 2, number of synchronizer flops on `sig_in`; must be >= 2.

Ports:
- clkin  in  1  system clock; all logic on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- en  in  1  measurement enable; synchronous level.
- sig_in  in  1  signal under measurement; asynchronous to `clkin`.
- freq_count  out  CNT_W  rising edges counted in the last completed gate window.
- freq_valid  out  1  one-cycle pulse when `freq_count` updates.
- period  out  CNT_W  `clkin` cycles between the last two detected edges.
- period_valid  out  1  one-cycle pulse when `period` updates.
- no_signal  out  1  1 = the last completed window held zero edges.

Behaviour:
- Reset (`rstn`=0, asynchronous): every flop clears, including the synchronizer, the previous-sample flop, all counters and the state. All outputs are 0. The FSM enters IDLE.
- Synchronizer: `sig_in` passes through SYNC_STAGES flops, then one previous-sample flop.
  - edge = sync_out & ~prev.
  - A rising edge of `sig_in` produces `edge` SYNC_STAGES+1 cycles later. The synchronizer runs regardless of `en`.
- FSM states: IDLE and GATE.
  - IDLE: gate_cnt=0, edge_cnt=0, period_armed=0. When `en`=1, go to GATE on the next cycle.
  - GATE: gate_cnt increments each cycle, running from 0 to GATE_CYCLES-1.
  - GATE exits to IDLE when `en`=0. The partial window is discarded, no pulses are issued, and `freq_count`, `period` and `no_signal` hold their last values.
- Window end: the GATE cycle with gate_cnt == GATE_CYCLES-1.
  - freq_count <= edge_cnt + edge, saturating. An edge on the boundary cycle belongs to the ending window.
  - freq_valid=1 for that cycle.
  - no_signal <= (that total == 0).
  - gate_cnt <= 0 and edge_cnt <= 0. The next window starts with no dead cycle.
- Otherwise in GATE: edge_cnt += edge. It saturates at 2^CNT_W-1 and never wraps.
- Period measurement (GATE only):
  - On edge with period_armed=0: set period_armed=1, set per_cnt <= 1, no pulse.
  - On edge with period_armed=1: period <= per_cnt, period_valid=1 for one cycle, per_cnt <= 1.
  - Non-edge cycles: per_cnt += 1, saturating at all-ones.
  - Example: edges at cycles t and t+N give period = N.
  - Saturated per_cnt is reported as all-ones on the next edge.
- Gate and period logic are independent. freq_valid and period_valid may assert in the same cycle.
- Re-entering GATE from IDLE re-arms period measurement: the first edge only arms.
- Reset mid-window: takes effect immediately, no pulse, outputs 0. After release, measurement restarts from IDLE.

Test Plan:
- Reset: assert `rstn`=0 with `sig_in` toggling -> all outputs 0 throughout; after release with `en`=0, outputs stay 0 and no pulses.
- GATE_CYCLES=100, `sig_in` period 10 (5 high/5 low), `en`=1 -> first freq_valid 100 cycles after entering GATE.
  - freq_count=10, pulse repeats every 100 cycles.
  - period=10 with period_valid every 10 cycles; no_signal=0.
- `sig_in` held 0, `en`=1 -> freq_valid every 100 cycles, freq_count=0, no_signal=1, period_valid never asserts.
- Edge placed exactly on the gate_cnt==99 cycle -> counted in the ending window (freq_count includes it); the next window starts at 0.
- Drop `en` at gate_cnt=50, re-raise 20 cycles later -> no pulse for the aborted window; outputs hold previous values.
  - Next freq_valid comes 100 cycles after re-entering GATE.
  - The first post-enable edge gives no period_valid.
- CNT_W=4, GATE_CYCLES=100, `sig_in` period 4 -> freq_count=15 (saturated, not 25 mod 16 = 9).
  - `sig_in` period 20 -> period=15 (saturated).
- Async reset pulse at gate_cnt=60 -> outputs 0 immediately, no freq_valid; after release, the full 100-cycle window is measured afresh.
